pc_decode_alu: RTL and testbench

Single-cycle MIPS-subset core slice combining the program counter, the instruction decoder and the ALU. It takes a fetched instruction and the two register-file read values. It produces decode control signals, the ALU result, and the current PC, which advances on the falling clock edge. Instruction ROM, register file, data RAM and the syscall/halt registers sit outside this block.

---
 rtl/pc_decode_alu.sv | 167 ++++++++++++++++
 tb/tb_pc_decode_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_decode_alu.sv
// Single-cycle MIPS-subset slice: PC register (falling edge), instruction decoder and ALU.
// Everything except pc is combinational from pc, instruction and the register-file values.
module pc_decode_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [31:0] instruction,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] alu_result,
    output logic        alu_eq,
    output logic [3:0]  aluop,
    output logic        reg_dst,
    output logic        reg_we,
    output logic        branch,
    output logic        jump,
    output logic        mem_we,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic        shift,
    output logic        equ,
    output logic        jump_reg,
    output logic        jal,
    output logic        usign,
    output logic        sys,
    output logic        shift_var,
    output logic        load_imm
);

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRA  = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      shamt;
    logic [15:0]     imm;
    logic [25:0]     addr;
    logic            r_alu;
    logic [XLEN-1:0] ext_imm;
    logic [XLEN-1:0] alu_x;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] next_pc;

    assign op    = instruction[31:26];
    assign funct = instruction[5:0];
    assign shamt = instruction[10:6];
    assign imm   = instruction[15:0];
    assign addr  = instruction[25:0];

    // Decoder: anything not matched leaves all controls at zero.
    always_comb begin
        aluop      = ALU_SLL;
        r_alu      = 1'b0;
        reg_dst    = 1'b0;
        reg_we     = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        shift      = 1'b0;
        equ        = 1'b0;
        jump_reg   = 1'b0;
        jal        = 1'b0;
        usign      = 1'b0;
        sys        = 1'b0;
        shift_var  = 1'b0;
        load_imm   = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: begin r_alu = 1'b1; aluop = ALU_ADD;  end
                    6'h22, 6'h23: begin r_alu = 1'b1; aluop = ALU_SUB;  end
                    6'h24:        begin r_alu = 1'b1; aluop = ALU_AND;  end
                    6'h25:        begin r_alu = 1'b1; aluop = ALU_OR;   end
                    6'h26:        begin r_alu = 1'b1; aluop = ALU_XOR;  end
                    6'h27:        begin r_alu = 1'b1; aluop = ALU_NOR;  end
                    6'h2A:        begin r_alu = 1'b1; aluop = ALU_SLT;  end
                    6'h2B:        begin r_alu = 1'b1; aluop = ALU_SLTU; end
                    6'h00: begin r_alu = 1'b1; shift = 1'b1; aluop = ALU_SLL; end
                    6'h02: begin r_alu = 1'b1; shift = 1'b1; aluop = ALU_SRL; end
                    6'h03: begin r_alu = 1'b1; shift = 1'b1; aluop = ALU_SRA; end
                    6'h04: begin r_alu = 1'b1; shift = 1'b1; shift_var = 1'b1; aluop = ALU_SLL; end
                    6'h06: begin r_alu = 1'b1; shift = 1'b1; shift_var = 1'b1; aluop = ALU_SRL; end
                    6'h07: begin r_alu = 1'b1; shift = 1'b1; shift_var = 1'b1; aluop = ALU_SRA; end
                    6'h08: jump_reg = 1'b1;
                    6'h0C: sys = 1'b1;
                    default: ;
                endcase
                reg_dst = r_alu;
                reg_we  = r_alu;
            end
            6'h08, 6'h09: begin alu_src = 1'b1; reg_we = 1'b1; aluop = ALU_ADD;  end
            6'h0A:        begin alu_src = 1'b1; reg_we = 1'b1; aluop = ALU_SLT;  end
            6'h0B:        begin alu_src = 1'b1; reg_we = 1'b1; aluop = ALU_SLTU; end
            6'h0C: begin alu_src = 1'b1; reg_we = 1'b1; usign = 1'b1; aluop = ALU_AND; end
            6'h0D: begin alu_src = 1'b1; reg_we = 1'b1; usign = 1'b1; aluop = ALU_OR;  end
            6'h0E: begin alu_src = 1'b1; reg_we = 1'b1; usign = 1'b1; aluop = ALU_XOR; end
            6'h0F: begin load_imm = 1'b1; reg_we = 1'b1; end
            6'h23: begin alu_src = 1'b1; mem_to_reg = 1'b1; reg_we = 1'b1; aluop = ALU_ADD; end
            6'h2B: begin alu_src = 1'b1; mem_we = 1'b1; aluop = ALU_ADD; end
            6'h04: begin branch = 1'b1; equ = 1'b1; aluop = ALU_SUB; end
            6'h05: begin branch = 1'b1; aluop = ALU_SUB; end
            6'h02: jump = 1'b1;
            6'h03: begin jump = 1'b1; jal = 1'b1; reg_we = 1'b1; end
            default: ;
        endcase
    end

    // Operand muxing: shifts take the value from rt and the amount from shamt or rs.
    assign ext_imm = usign ? {16'd0, imm} : {{16{imm[15]}}, imm};
    assign alu_x   = shift ? rt_data : rs_data;
    assign alu_y   = shift ? (shift_var ? rs_data : {27'd0, shamt})
                           : (alu_src ? ext_imm : rt_data);
    assign alu_eq  = (alu_x == alu_y);

    always_comb begin
        alu_result = '0;
        case (aluop)
            ALU_SLL:  alu_result = alu_x << alu_y[4:0];
            ALU_SRA:  alu_result = XLEN'($signed(alu_x) >>> alu_y[4:0]);
            ALU_SRL:  alu_result = alu_x >> alu_y[4:0];
            ALU_ADD:  alu_result = alu_x + alu_y;
            ALU_SUB:  alu_result = alu_x - alu_y;
            ALU_AND:  alu_result = alu_x & alu_y;
            ALU_OR:   alu_result = alu_x | alu_y;
            ALU_XOR:  alu_result = alu_x ^ alu_y;
            ALU_NOR:  alu_result = ~(alu_x | alu_y);
            ALU_SLT:  alu_result = {31'd0, $signed(alu_x) < $signed(alu_y)};
            ALU_SLTU: alu_result = {31'd0, alu_x < alu_y};
            default:  alu_result = '0;
        endcase
    end

    assign pc4 = pc + 32'd4;

    always_comb begin
        next_pc = pc4;
        if (jump_reg)
            next_pc = rs_data;
        else if (jump)
            next_pc = {pc4[31:28], addr, 2'b00};
        else if (branch && (alu_eq == equ))
            next_pc = pc4 + {{14{imm[15]}}, imm, 2'b00};
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            pc <= '0;
        else if (!halt)
            pc <= next_pc;
    end

endmodule

// File: tb/tb_pc_decode_alu.sv
// Directed bench for pc_decode_alu: decode/ALU vector table plus PC sequencing checks.
module tb_pc_decode_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic [31:0] instruction;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] alu_result;
    logic        alu_eq;
    logic [3:0]  aluop;
    logic reg_dst, reg_we, branch, jump, mem_we, mem_to_reg, alu_src, shift;
    logic equ, jump_reg, jal, usign, sys, shift_var, load_imm;

    int checks = 0;
    int failures = 0;

    pc_decode_alu dut (
        .clk(clk), .rst(rst), .halt(halt), .instruction(instruction),
        .rs_data(rs_data), .rt_data(rt_data), .pc(pc), .pc4(pc4),
        .alu_result(alu_result), .alu_eq(alu_eq), .aluop(aluop),
        .reg_dst(reg_dst), .reg_we(reg_we), .branch(branch), .jump(jump),
        .mem_we(mem_we), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .shift(shift), .equ(equ), .jump_reg(jump_reg), .jal(jal),
        .usign(usign), .sys(sys), .shift_var(shift_var), .load_imm(load_imm)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] C_RD  = 15'h4000;
    localparam logic [14:0] C_RW  = 15'h2000;
    localparam logic [14:0] C_BR  = 15'h1000;
    localparam logic [14:0] C_J   = 15'h0800;
    localparam logic [14:0] C_MW  = 15'h0400;
    localparam logic [14:0] C_MR  = 15'h0200;
    localparam logic [14:0] C_AS  = 15'h0100;
    localparam logic [14:0] C_SH  = 15'h0080;
    localparam logic [14:0] C_EQ  = 15'h0040;
    localparam logic [14:0] C_JR  = 15'h0020;
    localparam logic [14:0] C_JAL = 15'h0010;
    localparam logic [14:0] C_US  = 15'h0008;
    localparam logic [14:0] C_SYS = 15'h0004;
    localparam logic [14:0] C_SV  = 15'h0002;
    localparam logic [14:0] C_LI  = 15'h0001;

    logic [18:0] act_ctrl;
    assign act_ctrl = {aluop, reg_dst, reg_we, branch, jump, mem_we, mem_to_reg, alu_src,
                       shift, equ, jump_reg, jal, usign, sys, shift_var, load_imm};

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] res;
        logic        eq;
        logic [18:0] ctrl;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sa);
        return {6'h00, 5'd1, 5'd2, 5'd3, sa, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [15:0] im);
        return {opc, 5'd1, 5'd2, im};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Apply one instruction for a full cycle and check where pc lands.
    task automatic run_pc(input string nm, input logic [31:0] ins, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] exp_pc);
        instruction = ins;
        rs_data = rs;
        rt_data = rt;
        step();
        check(nm, pc, exp_pc);
    endtask

    initial begin
        vecs[0]  = '{"addu",    rtype(6'h21, 5'd0), 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, {4'd5, C_RD | C_RW}};
        vecs[1]  = '{"slt",     rtype(6'h2A, 5'd0), 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, {4'd11, C_RD | C_RW}};
        vecs[2]  = '{"sltu",    rtype(6'h2B, 5'd0), 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, {4'd12, C_RD | C_RW}};
        vecs[3]  = '{"nor",     rtype(6'h27, 5'd0), 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1, {4'd10, C_RD | C_RW}};
        vecs[4]  = '{"sra",     rtype(6'h03, 5'd4), 32'h12345678, 32'h80000000, 32'hF8000000, 1'b0, {4'd1, C_RD | C_RW | C_SH}};
        vecs[5]  = '{"srlv",    rtype(6'h06, 5'd0), 32'd36, 32'hF0, 32'h0F, 1'b0, {4'd2, C_RD | C_RW | C_SH | C_SV}};
        vecs[6]  = '{"ori",     itype(6'h0D, 16'h8000), 32'h0, 32'h0, 32'h00008000, 1'b0, {4'd8, C_AS | C_RW | C_US}};
        vecs[7]  = '{"addi",    itype(6'h08, 16'hFFFF), 32'd5, 32'h0, 32'd4, 1'b0, {4'd5, C_AS | C_RW}};
        vecs[8]  = '{"lui",     itype(6'h0F, 16'h1234), 32'h1, 32'h2, 32'h4, 1'b0, {4'd0, C_LI | C_RW}};
        vecs[9]  = '{"jal",     {6'h03, 26'h40}, 32'h0, 32'h0, 32'h0, 1'b1, {4'd0, C_J | C_JAL | C_RW}};
        vecs[10] = '{"syscall", rtype(6'h0C, 5'd0), 32'd3, 32'd1, 32'd6, 1'b0, {4'd0, C_SYS}};
        vecs[11] = '{"op3f",    itype(6'h3F, 16'h0000), 32'd3, 32'd1, 32'd6, 1'b0, {4'd0, 15'h0}};
        vecs[12] = '{"subu",    rtype(6'h23, 5'd0), 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, {4'd6, C_RD | C_RW}};
        vecs[13] = '{"xori",    itype(6'h0E, 16'hFFFF), 32'h0000FF00, 32'h0, 32'h000000FF, 1'b0, {4'd9, C_AS | C_RW | C_US}};
        vecs[14] = '{"sw",      itype(6'h2B, 16'hFFFC), 32'h100, 32'h0, 32'hFC, 1'b0, {4'd5, C_AS | C_MW}};
        vecs[15] = '{"lw",      itype(6'h23, 16'h0008), 32'h100, 32'h0, 32'h108, 1'b0, {4'd5, C_AS | C_MR | C_RW}};
        vecs[16] = '{"beq",     itype(6'h04, 16'hFFFF), 32'd9, 32'd9, 32'h0, 1'b1, {4'd6, C_BR | C_EQ}};
        vecs[17] = '{"sllv",    rtype(6'h04, 5'd0), 32'd33, 32'd1, 32'd2, 1'b0, {4'd0, C_RD | C_RW | C_SH | C_SV}};
        vecs[18] = '{"jr",      rtype(6'h08, 5'd0), 32'd3, 32'd1, 32'd6, 1'b0, {4'd0, C_JR}};
        vecs[19] = '{"andi",    itype(6'h0C, 16'h00F0), 32'hFFFFFF3C, 32'h0, 32'h30, 1'b0, {4'd7, C_AS | C_RW | C_US}};
        vecs[20] = '{"bne",     itype(6'h05, 16'hFFFF), 32'd9, 32'd9, 32'h0, 1'b1, {4'd6, C_BR}};
        vecs[21] = '{"j",       {6'h02, 26'h40}, 32'h0, 32'h0, 32'h0, 1'b1, {4'd0, C_J}};

        rst = 1'b1;
        halt = 1'b0;
        instruction = 32'h0;
        rs_data = 32'h0;
        rt_data = 32'h0;
        #1;
        check("reset_pc", pc, 32'h0);
        step();
        check("reset_hold", pc, 32'h0);
        rst = 1'b0;
        step();
        check("pc_first", pc, 32'h4);
        step();
        check("pc_second", pc, 32'h8);

        halt = 1'b1;
        step();
        step();
        check("halt_pc", pc, 32'h8);
        check("halt_pc4", pc4, 32'hC);

        // Combinational decode/ALU table with the PC frozen.
        for (int i = 0; i < NVEC; i++) begin
            instruction = vecs[i].instr;
            rs_data = vecs[i].rs;
            rt_data = vecs[i].rt;
            #2;
            check({vecs[i].name, "_result"}, alu_result, vecs[i].res);
            check({vecs[i].name, "_eq"}, 32'(alu_eq), 32'(vecs[i].eq));
            check({vecs[i].name, "_ctrl"}, 32'(act_ctrl), 32'(vecs[i].ctrl));
        end
        step();
        check("halt_after_table", pc, 32'h8);

        // Asynchronous reset in the middle of the low phase, no edge needed.
        halt = 1'b0;
        instruction = 32'h0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", pc, 32'h0);
        step();
        check("async_rst_hold", pc, 32'h0);
        rst = 1'b0;

        run_pc("j_0x100", {6'h02, 26'h40}, 32'h0, 32'h0, 32'h100);
        run_pc("beq_taken", itype(6'h04, 16'hFFFF), 32'd9, 32'd9, 32'h100);
        run_pc("bne_not_taken", itype(6'h05, 16'hFFFF), 32'd9, 32'd9, 32'h104);
        run_pc("bne_taken", itype(6'h05, 16'h0003), 32'd9, 32'd8, 32'h114);
        run_pc("jr_high", rtype(6'h08, 5'd0), 32'h10000000, 32'h0, 32'h10000000);
        run_pc("j_region", {6'h02, 26'h40}, 32'h0, 32'h0, 32'h10000100);
        run_pc("jr_3c", rtype(6'h08, 5'd0), 32'h3C, 32'h0, 32'h3C);
        run_pc("op3f_advance", itype(6'h3F, 16'h0000), 32'h0, 32'h0, 32'h40);
        run_pc("jr_top", rtype(6'h08, 5'd0), 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC);
        check("wrap_pc4", pc4, 32'h0);
        run_pc("wrap_pc", 32'h0, 32'h0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
